// File: rtl/seq_control_unit_pkg.sv
// Shared CPU package: control-unit state encodings and defaults.
// Reused by the sequencer, datapath and debug logic.
package seq_control_unit_pkg;

  localparam logic [2:0] ST_COMMIT  = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_MEM     = 3'd4;

  localparam int MEM_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    CNT_HOLD,
    CNT_LOAD,
    CNT_DEC,
    CNT_INC,
    CNT_CLR
  } cnt_op_t;

  typedef struct packed {
    logic wr_rd;
    logic upd;
    logic br;
    logic mop;
    logic mwr;
  } ctl_t;

endpackage

// File: rtl/seq_control_unit_if.sv
// Control-unit bundle: decoded controls and handshakes in,
// phase, memory-request and commit strobes out.
interface seq_control_unit_if #(
  parameter int EXEC_CNT_W = 4
);
  logic                  if_ready;
  logic                  update_flags;
  logic                  write_rd;
  logic                  br_en;
  logic                  ig_ex;
  logic                  mem_op;
  logic                  mem_wr;
  logic [EXEC_CNT_W-1:0] exec_cycles;
  logic                  mem_ready;

  logic       cu_fetch;
  logic       cu_decode;
  logic       cu_execute;
  logic       cu_mem;
  logic       cu_rd_mem;
  logic       cu_wr_mem;
  logic       new_pc_en;
  logic       ld_pc;
  logic       ld_rd;
  logic       ld_apsr;
  logic       cu_branch;
  logic       bus_fault;
  logic       busy;
  logic [2:0] state;

  modport master (
    output if_ready, update_flags, write_rd, br_en,
    output ig_ex, mem_op, mem_wr, exec_cycles, mem_ready,
    input  cu_fetch, cu_decode, cu_execute, cu_mem,
    input  cu_rd_mem, cu_wr_mem, new_pc_en, ld_pc,
    input  ld_rd, ld_apsr, cu_branch, bus_fault,
    input  busy, state
  );

  modport slave (
    input  if_ready, update_flags, write_rd, br_en,
    input  ig_ex, mem_op, mem_wr, exec_cycles, mem_ready,
    output cu_fetch, cu_decode, cu_execute, cu_mem,
    output cu_rd_mem, cu_wr_mem, new_pc_en, ld_pc,
    output ld_rd, ld_apsr, cu_branch, bus_fault,
    output busy, state
  );
endinterface

// File: rtl/seq_control_unit_counter.sv
// Shared cycle counter: down-counts execute cycles,
// up-counts memory wait cycles.
module cu_cycle_counter
  import seq_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  cnt_op_t    op,
  input  logic [7:0] load_val,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case (op)
        CNT_LOAD: count <= load_val;
        CNT_DEC:  count <= count - 8'd1;
        CNT_INC:  count <= count + 8'd1;
        CNT_CLR:  count <= '0;
        default:  count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle sequencer: fetch, decode, execute, memory, commit,
// with a memory-wait timeout that suppresses the commit writes.
module seq_control_unit
  import seq_control_unit_pkg::*;
#(
  parameter int EXEC_CNT_W  = 4,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input logic             clk,
  input logic             rst,
  seq_control_unit_if.slave cu
);

  logic [2:0]            st_q;
  logic [2:0]            st_d;
  ctl_t                  ctl_q;
  logic                  fault_q;
  cnt_op_t               op;
  logic [7:0]            cnt;
  logic [EXEC_CNT_W-1:0] ec;
  logic                  cnt_zero;
  logic                  tmo;

  assign ec       = cu.exec_cycles;
  assign cnt_zero = (cnt == 8'd0);

  // Fires on the MEM cycle whose not-ready wait would reach the limit.
  assign tmo = (st_q == ST_MEM) && !cu.mem_ready
            && (cnt == 8'(MEM_TIMEOUT - 1));

  cu_cycle_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .load_val (8'(ec)),
    .count    (cnt)
  );

  always_comb begin
    st_d = ST_COMMIT;
    op   = CNT_HOLD;
    unique case (st_q)
      ST_COMMIT: st_d = ST_FETCH;
      ST_FETCH:  st_d = cu.if_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        op   = CNT_LOAD;
        st_d = cu.ig_ex ? ST_COMMIT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (cnt_zero) begin
          op   = CNT_CLR;
          st_d = ctl_q.mop ? ST_MEM : ST_COMMIT;
        end else begin
          op   = CNT_DEC;
          st_d = ST_EXECUTE;
        end
      end
      ST_MEM: begin
        if (cu.mem_ready || tmo) begin
          st_d = ST_COMMIT;
        end else begin
          op   = CNT_INC;
          st_d = ST_MEM;
        end
      end
      default: st_d = ST_COMMIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_COMMIT;
      ctl_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_q == ST_DECODE) begin
        ctl_q <= '{
          wr_rd: cu.write_rd,
          upd:   cu.update_flags,
          br:    cu.br_en,
          mop:   cu.mem_op,
          mwr:   cu.mem_wr
        };
      end
      if (tmo) begin
        fault_q <= 1'b1;
      end else if (st_q == ST_COMMIT) begin
        fault_q <= 1'b0;
      end
    end
  end

  always_comb begin
    cu.cu_fetch   = 1'b0;
    cu.cu_decode  = 1'b0;
    cu.cu_execute = 1'b0;
    cu.cu_mem     = 1'b0;
    cu.cu_rd_mem  = 1'b0;
    cu.cu_wr_mem  = 1'b0;
    cu.new_pc_en  = 1'b0;
    cu.ld_pc      = 1'b0;
    cu.ld_rd      = 1'b0;
    cu.ld_apsr    = 1'b0;
    cu.cu_branch  = 1'b0;
    cu.bus_fault  = 1'b0;
    cu.busy       = 1'b0;
    cu.state      = st_q;
    unique case (st_q)
      ST_COMMIT: begin
        cu.new_pc_en = 1'b1;
        cu.ld_pc     = 1'b1;
        cu.ld_rd     = ctl_q.wr_rd & ~fault_q;
        cu.ld_apsr   = ctl_q.upd & ~fault_q;
        cu.cu_branch = ctl_q.br & ~fault_q;
      end
      ST_FETCH: begin
        cu.busy     = 1'b1;
        cu.cu_fetch = 1'b1;
      end
      ST_DECODE: begin
        cu.busy      = 1'b1;
        cu.cu_decode = 1'b1;
      end
      ST_EXECUTE: begin
        cu.busy       = 1'b1;
        cu.cu_execute = 1'b1;
      end
      ST_MEM: begin
        cu.busy      = 1'b1;
        cu.cu_mem    = 1'b1;
        cu.cu_rd_mem = ~ctl_q.mwr;
        cu.cu_wr_mem = ctl_q.mwr;
        cu.bus_fault = tmo & ~rst;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Randomized bench for seq_control_unit against an
// instruction-level timing model.
module tb_seq_control_unit;
  import seq_control_unit_pkg::*;

  localparam int EW  = 4;
  localparam int TMO = 15;

  typedef struct packed {
    logic       busy;
    logic [2:0] st;
    logic f, d, e, m;
    logic rdm, wrm;
    logic npc, lpc, lrd, lap, br, bf;
  } obs_t;

  typedef struct {
    logic ifr, mr, wr, uf, br, ig, mop, mwr;
    logic [EW-1:0] ec;
    obs_t exp;
  } step_t;

  typedef struct {
    int w, e, d;
    bit ig, mop, mwr, wr, uf, br;
  } insn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_control_unit_if #(.EXEC_CNT_W(EW)) bus ();

  seq_control_unit #(
    .EXEC_CNT_W  (EW),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cu  (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  step_t plan[$];
  int st_log[$];
  int n_exec, n_mem, n_wr, n_flt, flt_at;
  obs_t last_c;

  function automatic obs_t mk(input int ph, input bit wm,
                              input bit [2:0] cs, input bit flt);
    obs_t o;
    o = '0;
    o.st = 3'(ph);
    o.busy = (ph != 0);
    case (ph)
      0: begin
        o.npc = 1'b1;
        o.lpc = 1'b1;
        {o.lrd, o.lap, o.br} = cs;
      end
      1: o.f = 1'b1;
      2: o.d = 1'b1;
      3: o.e = 1'b1;
      4: begin
        o.m   = 1'b1;
        o.rdm = !wm;
        o.wrm = wm;
        o.bf  = flt;
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = bus.busy;
    o.st   = bus.state;
    o.f    = bus.cu_fetch;
    o.d    = bus.cu_decode;
    o.e    = bus.cu_execute;
    o.m    = bus.cu_mem;
    o.rdm  = bus.cu_rd_mem;
    o.wrm  = bus.cu_wr_mem;
    o.npc  = bus.new_pc_en;
    o.lpc  = bus.ld_pc;
    o.lrd  = bus.ld_rd;
    o.lap  = bus.ld_apsr;
    o.br   = bus.cu_branch;
    o.bf   = bus.bus_fault;
    return o;
  endfunction

  function automatic step_t rnd_step();
    step_t s;
    s.ifr = 1'($urandom);
    s.mr  = 1'($urandom);
    s.wr  = 1'($urandom);
    s.uf  = 1'($urandom);
    s.br  = 1'($urandom);
    s.ig  = 1'($urandom);
    s.mop = 1'($urandom);
    s.mwr = 1'($urandom);
    s.ec  = EW'($urandom);
    s.exp = '0;
    return s;
  endfunction

  task automatic clr_tally();
    n_exec = 0;
    n_mem  = 0;
    n_wr   = 0;
    n_flt  = 0;
    flt_at = 0;
    st_log.delete();
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic step(input step_t s, input logic r);
    obs_t act;
    rst              = r;
    bus.if_ready     = s.ifr;
    bus.mem_ready    = s.mr;
    bus.write_rd     = s.wr;
    bus.update_flags = s.uf;
    bus.br_en        = s.br;
    bus.ig_ex        = s.ig;
    bus.mem_op       = s.mop;
    bus.mem_wr       = s.mwr;
    bus.exec_cycles  = s.ec;
    @(negedge clk);
    act = sample();
    total++;
    if (act !== s.exp) begin
      bad++;
      $display("FAIL cycle%0d got=%h want=%h", cyc, act, s.exp);
    end
    st_log.push_back(int'(act.st));
    if (act.st == 3'd3) n_exec++;
    if (act.st == 3'd4) n_mem++;
    if (act.wrm) n_wr++;
    if (act.bf) begin
      n_flt++;
      flt_at = n_mem;
    end
    if (act.st == 3'd0) last_c = act;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic build(input insn_t n);
    step_t s;
    bit flt;
    flt = 1'b0;
    plan.delete();
    for (int k = 0; k <= n.w; k++) begin
      s = rnd_step();
      s.ifr = (k == n.w);
      s.exp = mk(1, 0, 3'b0, 0);
      plan.push_back(s);
    end
    s = rnd_step();
    s.wr  = n.wr;
    s.uf  = n.uf;
    s.br  = n.br;
    s.ig  = n.ig;
    s.mop = n.mop;
    s.mwr = n.mwr;
    s.ec  = EW'(n.e);
    s.exp = mk(2, 0, 3'b0, 0);
    plan.push_back(s);
    if (!n.ig) begin
      for (int k = 0; k <= n.e; k++) begin
        s = rnd_step();
        s.exp = mk(3, 0, 3'b0, 0);
        plan.push_back(s);
      end
      if (n.mop && n.d >= TMO) begin
        for (int k = 0; k < TMO; k++) begin
          s = rnd_step();
          s.mr = 1'b0;
          s.exp = mk(4, n.mwr, 3'b0, k == TMO - 1);
          plan.push_back(s);
        end
        flt = 1'b1;
      end else if (n.mop) begin
        for (int k = 0; k <= n.d; k++) begin
          s = rnd_step();
          s.mr = (k == n.d);
          s.exp = mk(4, n.mwr, 3'b0, 0);
          plan.push_back(s);
        end
      end
    end
    s = rnd_step();
    s.exp = mk(0, 0, flt ? 3'b0 : {n.wr, n.uf, n.br}, 0);
    plan.push_back(s);
  endtask

  task automatic run_plan(input int abort_at);
    step_t c;
    foreach (plan[i]) begin
      step(plan[i], i == abort_at);
      if (i == abort_at) begin
        c = rnd_step();
        c.exp = mk(0, 0, 3'b0, 0);
        step(c, 1'b0);
        return;
      end
    end
  endtask

  task automatic run_insn(input insn_t n);
    clr_tally();
    build(n);
    run_plan(-1);
  endtask

  function automatic int log_at(input int i);
    return (i < st_log.size()) ? st_log[i] : -1;
  endfunction

  initial begin
    insn_t n;
    step_t s;
    rst = 1'b1;
    s = rnd_step();
    bus.if_ready = 0; bus.mem_ready = 0;
    bus.write_rd = 0; bus.update_flags = 0;
    bus.br_en = 0; bus.ig_ex = 0;
    bus.mem_op = 0; bus.mem_wr = 0;
    bus.exec_cycles = '0;
    repeat (2) @(posedge clk);
    #1;

    clr_tally();
    s.exp = mk(0, 0, 3'b0, 0);
    step(s, 1'b0);
    chk("rst_state", int'(last_c.st), 0);
    chk("rst_ld_pc", int'(last_c.lpc), 1);
    chk("rst_new_pc", int'(last_c.npc), 1);
    chk("rst_ld_rd", int'(last_c.lrd), 0);
    chk("rst_fault", int'(last_c.bf), 0);
    chk("rst_memreq", int'({last_c.rdm, last_c.wrm}), 0);

    n = '{w:0, e:0, d:0, ig:1, mop:0, mwr:0, wr:1, uf:0, br:0};
    run_insn(n);
    chk("ig_seq_len", st_log.size(), 3);
    chk("ig_seq0", log_at(0), 1);
    chk("ig_seq1", log_at(1), 2);
    chk("ig_seq2", log_at(2), 0);
    chk("ig_ld_rd", int'(last_c.lrd), 1);

    n = '{w:2, e:3, d:0, ig:0, mop:0, mwr:0, wr:0, uf:1, br:0};
    run_insn(n);
    chk("exec_cycles", n_exec, 4);
    chk("exec_ld_apsr", int'(last_c.lap), 1);

    n = '{w:0, e:1, d:5, ig:0, mop:1, mwr:1, wr:1, uf:0, br:1};
    run_insn(n);
    chk("st_wr_cycles", n_wr, 6);
    chk("st_no_fault", n_flt, 0);

    n = '{w:1, e:0, d:99, ig:0, mop:1, mwr:0, wr:1, uf:1, br:1};
    run_insn(n);
    chk("tmo_pulses", n_flt, 1);
    chk("tmo_cycle", flt_at, 15);
    chk("tmo_ld_rd", int'(last_c.lrd), 0);
    chk("tmo_ld_pc", int'(last_c.lpc), 1);

    n = '{w:0, e:0, d:TMO-1, ig:0, mop:1, mwr:0, wr:1, uf:0, br:0};
    run_insn(n);
    chk("race_fault", n_flt, 0);
    chk("race_ld_rd", int'(last_c.lrd), 1);

    n = '{w:0, e:7, d:0, ig:0, mop:1, mwr:1, wr:1, uf:1, br:1};
    clr_tally();
    build(n);
    run_plan(4);
    chk("abort_state", int'(last_c.st), 0);
    chk("abort_ld_rd", int'(last_c.lrd), 0);
    chk("abort_branch", int'(last_c.br), 0);
    chk("abort_ld_pc", int'(last_c.lpc), 1);
    chk("abort_fault", n_flt, 0);

    for (int i = 0; i < 200; i++) begin
      n.w   = $urandom_range(0, 3);
      n.ig  = ($urandom_range(0, 3) == 0);
      n.e   = ($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 5);
      n.mop = 1'($urandom);
      n.mwr = 1'($urandom);
      n.wr  = 1'($urandom);
      n.uf  = 1'($urandom);
      n.br  = 1'($urandom);
      if ($urandom_range(0, 3) == 0)
        n.d = $urandom_range(TMO - 2, TMO + 3);
      else
        n.d = $urandom_range(0, 6);
      run_insn(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
